scene_controller: RTL
=====================

SCENE_CONTROLLER -- requirements
Module: scene_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_FRAMES, default 4: consecutive sampled-high frames needed to accept StartKey.
REQ-002 SHALL have parameter RESULT_FRAMES, default 300: frames the result screen is held before auto-return to title.
REQ-003 SHALL have parameter FADE_FRAMES, fixed at 16, not overridable: length of the title fade-out in frames.
REQ-004 SHALL have port OriginalClk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port FrameTick, input, 1 bit: one-cycle pulse once per video frame.
REQ-007 SHALL have port StartKey, input, 1 bit: raw start-button level, already synchronous to OriginalClk.
REQ-008 SHALL have port SongDone, input, 1 bit: one-cycle pulse when the chart/song ends.
REQ-009 SHALL have ports BeginLayer, PlayLayer and EndLayer, input, 16 bits each: RGB565 pixels from the title, gameplay and result renderers.
REQ-010 SHALL have port PixelOut, output, 16 bits: registered RGB565 pixel to the VGA driver.
REQ-011 SHALL have port SceneState, output, 2 bits: current state (TITLE=0, FADE=1, PLAY=2, RESULT=3).
REQ-012 SHALL have port GameStart, output, 1 bit: one-cycle pulse on entry to PLAY.
REQ-013 SHALL have port GameRunning, output, 1 bit: high exactly while SceneState==PLAY.

Function
REQ-014 Debounce: StartKey SHALL be sampled only on FrameTick cycles; a 3-bit saturating counter increments when sampled high and clears when sampled low.
REQ-015 Debounced key (KeyStable) SHALL go high on the FrameTick when the counter reaches DEBOUNCE_FRAMES, and go low on the first FrameTick that samples StartKey low.
REQ-016 KeyPress SHALL be a one-cycle pulse on the 0->1 edge of KeyStable; a held key SHALL produce exactly one KeyPress.
REQ-017 TITLE -> FADE on KeyPress; the fade level counter (4 bits) SHALL clear to 0 on entry.
REQ-018 FADE: the level SHALL increment on each FrameTick; on the FrameTick where level==15, the state SHALL go to PLAY (16 frames total).
REQ-019 GameStart SHALL pulse for exactly the first cycle in which SceneState==PLAY.
REQ-020 PLAY -> RESULT on SongDone; the result frame counter (9 bits min.) SHALL clear on entry.
REQ-021 RESULT -> TITLE on KeyPress, or on the FrameTick where the result counter reaches RESULT_FRAMES-1, whichever comes first.
REQ-022 SongDone outside PLAY and KeyPress in FADE or PLAY SHALL be ignored; they SHALL NOT be queued.
REQ-023 A KeyPress from a key still held since TITLE SHALL NOT end RESULT; a release and re-press are required.
REQ-024 When FrameTick and SongDone arrive in the same cycle in PLAY, the controller SHALL enter RESULT with the result counter at 0 (the tick is not counted).
REQ-025 PixelOut SHALL be registered with 1-cycle latency from the layer inputs: TITLE->BeginLayer, PLAY->PlayLayer, RESULT->EndLayer.
REQ-026 In FADE, each channel SHALL be scaled as ch_out = (ch*(16-level))>>4, per R[15:11], G[10:5], B[4:0], with no overflow (intermediate width >= 10 bits).
REQ-027 Layer selection SHALL use the state and level registered before the current edge.

Reset
REQ-028 While Reset is high at a clock edge: SceneState=TITLE, PixelOut=16'h0000, GameStart=0, GameRunning=0, all counters 0, KeyStable=0.
REQ-029 Reset mid-FADE, mid-PLAY or mid-RESULT SHALL return to TITLE on the next edge, with no GameStart pulse.
REQ-030 A key held through reset release SHALL require DEBOUNCE_FRAMES fresh high samples before KeyPress.

Verification
REQ-031 Scenario: reset, BeginLayer=16'hFFFF, StartKey high for 4 ticks -> FADE; on the 1st FADE cycle PixelOut=16'hFFFF, at level 8 PixelOut=16'h7BEF.
REQ-032 Scenario: StartKey high for 3 ticks, low 1, high 3 -> no state change (glitch rejected).
REQ-033 Scenario: 16 FrameTicks in FADE -> PLAY, GameStart high exactly 1 cycle, GameRunning=1, PixelOut=PlayLayer one cycle later.
REQ-034 Scenario: SongDone during TITLE -> ignored; SongDone in PLAY -> RESULT; with no key, TITLE after exactly 300 ticks.
REQ-035 Scenario: key held from TITLE through RESULT -> no early exit; release then press 4 ticks -> TITLE.
REQ-036 Scenario: Reset asserted at FADE level 10 -> next cycle SceneState=0, PixelOut=0.

Source files
------------

// File: rtl/scene_controller.sv
// Scene sequencer for the rhythm game: TITLE -> FADE -> PLAY -> RESULT -> TITLE, with start-key debounce and frame fade.
// Latency: PixelOut is registered, one cycle behind the layer inputs; state changes take effect on the next clock edge.
// Backpressure: none; the pixel stream is free-running and every input is consumed in the cycle it arrives.
module scene_controller #(
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int RESULT_FRAMES   = 300
) (
    input  logic        OriginalClk,
    input  logic        Reset,
    input  logic        FrameTick,
    input  logic        StartKey,
    input  logic        SongDone,
    input  logic [15:0] BeginLayer,
    input  logic [15:0] PlayLayer,
    input  logic [15:0] EndLayer,
    output logic [15:0] PixelOut,
    output logic [1:0]  SceneState,
    output logic        GameStart,
    output logic        GameRunning
);

    // Fade length is a fixed property of the title artwork.
    localparam int FADE_FRAMES = 16;

    // Result counter is at least 9 bits, wider if the hold time needs it.
    localparam int RES_W = ($clog2(RESULT_FRAMES) > 9) ? $clog2(RESULT_FRAMES) : 9;

    localparam logic [2:0]       DEB_TH    = 3'(DEBOUNCE_FRAMES);
    localparam logic [2:0]       DEB_MAX   = 3'd7;
    localparam logic [3:0]       LVL_LAST  = 4'(FADE_FRAMES - 1);
    localparam logic [4:0]       FADE_FULL = 5'(FADE_FRAMES);
    localparam logic [RES_W-1:0] RES_LAST  = RES_W'(RESULT_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_TITLE  = 2'd0,
        ST_FADE   = 2'd1,
        ST_PLAY   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_deb_cnt;
    logic [2:0]       w_deb_next;
    logic             r_key_stable;
    logic             r_key_stable_d;
    logic             w_key_press;
    logic [3:0]       r_level;
    logic [RES_W-1:0] r_res_cnt;
    logic             r_was_play;
    logic [15:0]      r_pixel;
    logic [4:0]       w_scale;
    logic [4:0]       w_fade_r;
    logic [5:0]       w_fade_g;
    logic [4:0]       w_fade_b;
    logic [15:0]      w_fade_pix;

    // ------------------------------------------------------------------
    // Start-key debounce
    // ------------------------------------------------------------------

    // Saturating increment so a long hold never wraps back below threshold.
    always_comb begin
        w_deb_next = (r_deb_cnt == DEB_MAX) ? DEB_MAX : r_deb_cnt + 3'd1;
    end

    // Sample the key once per frame; any low sample restarts the count and drops KeyStable.
    always_ff @(posedge OriginalClk) begin
        if (Reset) begin
            r_deb_cnt    <= 3'd0;
            r_key_stable <= 1'b0;
        end else if (FrameTick) begin
            if (StartKey) begin
                r_deb_cnt <= w_deb_next;
                if (w_deb_next >= DEB_TH) begin
                    r_key_stable <= 1'b1;
                end
            end else begin
                r_deb_cnt    <= 3'd0;
                r_key_stable <= 1'b0;
            end
        end
    end

    // Delayed copy of KeyStable for rising-edge detection.
    always_ff @(posedge OriginalClk) begin
        if (Reset) begin
            r_key_stable_d <= 1'b0;
        end else begin
            r_key_stable_d <= r_key_stable;
        end
    end

    // One pulse per press: a held key stays stable and never re-triggers,
    // so a key held from TITLE cannot also end RESULT.
    always_comb begin
        w_key_press = r_key_stable & ~r_key_stable_d;
    end

    // ------------------------------------------------------------------
    // Scene FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge OriginalClk) begin
        if (Reset) begin
            r_state <= ST_TITLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; events that do not apply to the current scene are dropped, not queued.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_TITLE: begin
                if (w_key_press) begin
                    w_state_next = ST_FADE;
                end
            end
            ST_FADE: begin
                if (FrameTick && (r_level == LVL_LAST)) begin
                    w_state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (SongDone) begin
                    w_state_next = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (w_key_press || (FrameTick && (r_res_cnt == RES_LAST))) begin
                    w_state_next = ST_TITLE;
                end
            end
            default: w_state_next = ST_TITLE;
        endcase
    end

    // Remembers whether the previous cycle was PLAY, so GameStart marks only the first PLAY cycle.
    always_ff @(posedge OriginalClk) begin
        if (Reset) begin
            r_was_play <= 1'b0;
        end else begin
            r_was_play <= (r_state == ST_PLAY);
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        GameRunning = (r_state == ST_PLAY);
        GameStart   = (r_state == ST_PLAY) && !r_was_play;
    end

    assign SceneState = r_state;

    // ------------------------------------------------------------------
    // Scene counters
    // ------------------------------------------------------------------

    // Fade level: held at 0 outside FADE so it starts from 0 on entry; the 16th tick wraps it back to 0.
    always_ff @(posedge OriginalClk) begin
        if (Reset) begin
            r_level <= 4'd0;
        end else if (r_state != ST_FADE) begin
            r_level <= 4'd0;
        end else if (FrameTick) begin
            r_level <= r_level + 4'd1;
        end
    end

    // Result hold counter: only ticks seen while already in RESULT count,
    // so a tick arriving with SongDone leaves it at 0.
    always_ff @(posedge OriginalClk) begin
        if (Reset) begin
            r_res_cnt <= '0;
        end else if (r_state != ST_RESULT) begin
            r_res_cnt <= '0;
        end else if (FrameTick) begin
            r_res_cnt <= r_res_cnt + RES_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Pixel path
    // ------------------------------------------------------------------

    // Per-channel fade: ch * (16 - level) >> 4, done at 11 bits so 63*16 cannot overflow.
    always_comb begin
        w_scale    = FADE_FULL - {1'b0, r_level};
        w_fade_r   = 5'((11'(BeginLayer[15:11]) * 11'(w_scale)) >> 4);
        w_fade_g   = 6'((11'(BeginLayer[10:5])  * 11'(w_scale)) >> 4);
        w_fade_b   = 5'((11'(BeginLayer[4:0])   * 11'(w_scale)) >> 4);
        w_fade_pix = {w_fade_r, w_fade_g, w_fade_b};
    end

    // Layer select from the state and level held before this edge, registered toward the VGA driver.
    always_ff @(posedge OriginalClk) begin
        if (Reset) begin
            r_pixel <= 16'h0000;
        end else begin
            case (r_state)
                ST_TITLE:  r_pixel <= BeginLayer;
                ST_FADE:   r_pixel <= w_fade_pix;
                ST_PLAY:   r_pixel <= PlayLayer;
                ST_RESULT: r_pixel <= EndLayer;
                default:   r_pixel <= 16'h0000;
            endcase
        end
    end

    assign PixelOut = r_pixel;

endmodule
